// File: rtl/parking_gate_arbiter.sv
// Barrier gate arbiter: shares one gate between the entrance and exit lanes with
// alternating tie priority, an open-timeout, a post-service guard and lot occupancy.
module parking_gate_arbiter #(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 16,
  parameter int GUARD    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             gate_open,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy,
  output logic             timeout
);
  localparam int OT_W = $clog2(TIMEOUT);
  localparam int GT_W = $clog2(GUARD + 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {IDLE, OPEN_ENTRY, OPEN_EXIT, CLOSING} state_t;

  state_t          state, next_state;
  logic [OT_W-1:0] open_timer;
  logic [GT_W-1:0] guard_timer;
  logic            last_exit;
  logic            entry_valid, exit_valid, is_open, time_up, guard_done;

  assign entry_valid = entry_req && !full;
  assign exit_valid  = exit_req && !empty;
  assign is_open     = (state == OPEN_ENTRY) || (state == OPEN_EXIT);
  assign time_up     = open_timer == OT_W'(TIMEOUT - 1);
  assign guard_done  = guard_timer == GT_W'(GUARD - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (entry_valid && exit_valid) next_state = last_exit ? OPEN_ENTRY : OPEN_EXIT;
        else if (entry_valid)          next_state = OPEN_ENTRY;
        else if (exit_valid)           next_state = OPEN_EXIT;
      end
      OPEN_ENTRY, OPEN_EXIT: begin
        if (car_passed || time_up) next_state = CLOSING;
      end
      CLOSING: begin
        if (guard_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A pass on the final open cycle wins over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      open_timer  <= '0;
      guard_timer <= '0;
      last_exit   <= 1'b0;
      occupancy   <= '0;
      timeout     <= 1'b0;
    end else begin
      open_timer  <= (is_open && next_state == state) ? open_timer + 1'b1 : '0;
      guard_timer <= (state == CLOSING && next_state == CLOSING) ? guard_timer + 1'b1 : '0;
      timeout     <= is_open && !car_passed && time_up;
      if (state == IDLE && next_state == OPEN_ENTRY)     last_exit <= 1'b0;
      else if (state == IDLE && next_state == OPEN_EXIT) last_exit <= 1'b1;
      if (state == OPEN_ENTRY && car_passed && occupancy != CAP)
        occupancy <= occupancy + 1'b1;
      else if (state == OPEN_EXIT && car_passed && occupancy != '0)
        occupancy <= occupancy - 1'b1;
    end
  end

  always_comb begin
    gate_open   = is_open;
    entry_grant = (state == OPEN_ENTRY);
    exit_grant  = (state == OPEN_EXIT);
    full        = (occupancy == CAP);
    empty       = (occupancy == '0);
  end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: fixed vector table, directed corner sequences and
// a randomized run, all compared against a lane/counter level reference model.
module tb_parking_gate_arbiter;
  localparam int CAPACITY = 8;
  localparam int CNT_W    = 4;
  localparam int TIMEOUT  = 16;
  localparam int GUARD    = 2;

  logic clk = 1'b0;
  logic reset, entry_req, exit_req, car_passed;
  logic gate_open, entry_grant, exit_grant, full, empty, timeout;
  logic [CNT_W-1:0] occupancy;

  int vectors = 0;
  int errors  = 0;

  parking_gate_arbiter #(
    .CAPACITY(CAPACITY),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .GUARD   (GUARD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .car_passed (car_passed),
    .gate_open  (gate_open),
    .entry_grant(entry_grant),
    .exit_grant (exit_grant),
    .full       (full),
    .empty      (empty),
    .occupancy  (occupancy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: lane being served (-1 none, 0 entry, 1 exit), cycles spent open,
  // guard cycles still to wait, car count and the lane served most recently.
  int m_lane, m_open, m_guard, m_occ, m_last;
  bit m_tmo;

  typedef logic [CNT_W+5:0] obs_t;  // gate, entry, exit, timeout, full, empty, occupancy

  function automatic obs_t dut_obs();
    return {gate_open, entry_grant, exit_grant, timeout, full, empty, occupancy};
  endfunction

  function automatic obs_t model_obs();
    return {m_lane >= 0, m_lane == 0, m_lane == 1, m_tmo,
            m_occ == CAPACITY, m_occ == 0, CNT_W'(m_occ)};
  endfunction

  function automatic void model_reset();
    m_lane = -1; m_open = 0; m_guard = 0; m_occ = 0; m_last = 0; m_tmo = 0;
  endfunction

  function automatic void model_step();
    bit ev, xv;
    if (m_lane >= 0) begin
      if (car_passed) begin
        if (m_lane == 0) m_occ = (m_occ < CAPACITY) ? m_occ + 1 : m_occ;
        else             m_occ = (m_occ > 0) ? m_occ - 1 : 0;
        m_lane = -1; m_guard = GUARD; m_tmo = 0;
      end else if (m_open == TIMEOUT - 1) begin
        m_lane = -1; m_guard = GUARD; m_tmo = 1;
      end else begin
        m_open++; m_tmo = 0;
      end
    end else begin
      m_tmo = 0;
      if (m_guard > 0) m_guard--;
      else begin
        ev = entry_req && (m_occ < CAPACITY);
        xv = exit_req && (m_occ > 0);
        if (ev && xv) m_lane = (m_last == 0) ? 1 : 0;
        else if (ev)  m_lane = 0;
        else if (xv)  m_lane = 1;
        if (m_lane >= 0) begin
          m_last = m_lane; m_open = 0;
        end
      end
    end
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (gate,eg,xg,tmo,full,empty,occ)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, dut_obs(), model_obs());
  endtask

  task automatic serve(input bit ex, input int dwell);
    int n = 0;
    entry_req = !ex; exit_req = ex;
    do begin
      step("serve_wait"); n++;
    end while (!(ex ? exit_grant : entry_grant) && n < 8);
    entry_req = 0; exit_req = 0;
    check_int("serve_grant", ex ? exit_grant : entry_grant, 1);
    repeat (dwell) step("serve_dwell");
    car_passed = 1; step("serve_pass"); car_passed = 0;
    repeat (GUARD) step("serve_guard");
  endtask

  typedef struct {
    logic e, x, p;
    obs_t exp;
  } vec_t;

  function automatic vec_t mk(input logic e, x, p, g, eg, xg, input int occ);
    vec_t v;
    v.e = e; v.x = x; v.p = p;
    v.exp = {g, eg, xg, 1'b0, occ == CAPACITY, occ == 0, CNT_W'(occ)};
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    int opened, pulses, n, grants;

    reset = 1; entry_req = 0; exit_req = 0; car_passed = 0;
    model_reset();
    #2 check("reset_state", dut_obs(), model_obs());
    @(posedge clk); #1 reset = 0;

    // Entry service with pass 3 cycles after grant, then entry and exit services,
    // then car_passed while closing and idle.
    tbl[0]  = mk(1, 0, 0, 1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 1, 1, 0, 1);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 2);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 2);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 2);
    tbl[10] = mk(0, 1, 0, 1, 0, 1, 2);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 1, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      entry_req = tbl[i].e; exit_req = tbl[i].x; car_passed = tbl[i].p;
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("table[%0d]", i), dut_obs(), tbl[i].exp);
      check($sformatf("table_model[%0d]", i), dut_obs(), model_obs());
    end
    entry_req = 0; exit_req = 0; car_passed = 0;

    // Open timeout: gate open exactly TIMEOUT cycles, one timeout pulse.
    entry_req = 1; step("to_grant"); entry_req = 0;
    opened = 0; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (gate_open) opened++;
      if (timeout) pulses++;
      step("to_run");
    end
    if (timeout) pulses++;
    check_int("to_open_cycles", opened, TIMEOUT);
    check_int("to_pulses", pulses, 1);
    check_int("to_occ", occupancy, 1);

    // Pass on the last open cycle counts and suppresses the timeout.
    entry_req = 1; step("late_grant"); entry_req = 0;
    repeat (TIMEOUT - 1) step("late_open");
    car_passed = 1; step("late_pass"); car_passed = 0;
    check_int("late_occ", occupancy, 2);
    pulses = 0;
    repeat (5) begin
      if (timeout) pulses++;
      step("late_after");
    end
    check_int("late_no_timeout", pulses, 0);

    // Fill the lot; entry is then blocked, exit still served.
    repeat (CAPACITY - 2) serve(0, 1);
    check_int("fill_occ", occupancy, CAPACITY);
    check_int("fill_full", full, 1);
    entry_req = 1; grants = 0;
    repeat (6) begin
      step("full_block");
      if (entry_grant) grants++;
    end
    entry_req = 0;
    check_int("full_no_grant", grants, 0);
    serve(1, 2);
    check_int("unfill_occ", occupancy, CAPACITY - 1);
    check_int("unfill_full", full, 0);

    // Alternating priority from occupancy 3 with last served = entry.
    repeat (5) serve(1, 0);
    serve(0, 0);
    check_int("alt_start_occ", occupancy, 3);
    entry_req = 1; exit_req = 1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!gate_open && n < 8) begin
        step("alt_wait"); n++;
      end
      check_int("alt_grant_wait", gate_open, 1);
      check_int($sformatf("alt_lane[%0d]", k), exit_grant, (k % 2 == 0) ? 1 : 0);
      step("alt_dwell");
      car_passed = 1; step("alt_pass"); car_passed = 0;
      if (k % 2 == 1) check_int("alt_occ", occupancy, 3);
    end
    entry_req = 0; exit_req = 0;

    // Asynchronous reset while serving the exit lane at occupancy 5.
    serve(0, 0); serve(0, 0);
    check_int("pre_reset_occ", occupancy, 5);
    exit_req = 1; n = 0;
    do begin
      step("rst_wait"); n++;
    end while (!exit_grant && n < 8);
    check_int("rst_exit_open", exit_grant, 1);
    #3 reset = 1;
    #1;
    check_int("rst_gate", gate_open, 0);
    check_int("rst_exit_grant", exit_grant, 0);
    check_int("rst_occ", occupancy, 0);
    check_int("rst_empty", empty, 1);
    model_reset();
    exit_req = 0;
    @(posedge clk); #1 reset = 0;

    // Empty lot: exit ignored, stray car_passed pulses ignored.
    exit_req = 1; grants = 0;
    for (int i = 0; i < 10; i++) begin
      car_passed = (i % 3 == 0);
      step("empty_exit");
      if (exit_grant) grants++;
    end
    exit_req = 0; car_passed = 0;
    check_int("empty_no_grant", grants, 0);
    check_int("empty_occ", occupancy, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      entry_req  = ($urandom_range(0, 3) != 0);
      exit_req   = ($urandom_range(0, 2) == 0);
      car_passed = ($urandom_range(0, 9) == 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
